// File: rtl/mips_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module      : mips_regfile_dump
// Description : Sweeps read port 1 of the 8x32 MIPS register file over every
//               address and streams each captured word on a valid/ready
//               interface, keeping a running XOR checksum of accepted words.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_regfile_dump #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_rf_read_reg;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_out_index;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_checksum;

    // Every output is a flop; out_ready only steers next-state logic, so it
    // never reaches an output combinationally.
    assign rf_read_reg = r_rf_read_reg;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_index   = r_out_index;
    assign busy        = r_busy;
    assign done        = r_done;
    assign checksum    = r_checksum;

    // Sweep controller: address the register file, capture, hand off, advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_rf_read_reg <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_index   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_checksum    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A new dump always starts from address 0 with a fresh checksum.
                    if (start) begin
                        r_idx         <= '0;
                        r_rf_read_reg <= '0;
                        r_checksum    <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Snapshot the word; later register-file writes cannot disturb it.
                    r_out_data  <= rf_read_data;
                    r_out_index <= r_idx;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (r_out_ready_xfer(r_out_valid, out_ready)) begin
                        r_checksum  <= r_checksum ^ r_out_data;
                        r_out_valid <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx         <= r_idx + 1'b1;
                            r_rf_read_reg <= r_idx + 1'b1;
                            r_state       <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    // done lasts one cycle; start is ignored here as in any busy state.
                    r_done        <= 1'b0;
                    r_busy        <= 1'b0;
                    r_rf_read_reg <= '0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A word moves only when it is being offered and the consumer takes it.
    function automatic logic r_out_ready_xfer(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_regfile_dump
// Description : Directed self-checking bench for mips_regfile_dump with a
//               behavioural 8x32 register file on read port 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_regfile_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        out_ready;
    logic [2:0]  rf_read_reg;
    logic [31:0] rf_read_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_index;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic [31:0] regs [8];
    logic [31:0] exp_words [8];
    logic [31:0] model_sum;

    int checks    = 0;
    int failures  = 0;
    int xfer_cnt  = 0;
    int done_cnt  = 0;
    int xfer_base = 0;
    int done_base = 0;

    always #5 clk = ~clk;

    // Register file read port: r0 is hard-wired to zero.
    assign rf_read_data = (rf_read_reg == 3'd0) ? 32'd0 : regs[rf_read_reg];

    mips_regfile_dump #(.ADDR_W(3), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rf_read_reg  (rf_read_reg),
        .rf_read_data (rf_read_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum)
    );

    // Count handshakes and done pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
        if (!reset && done)                   done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_base_words();
        for (int i = 0; i < 8; i++)
            exp_words[i] = (i == 0) ? 32'd0 : (32'hA5A5_0000 | 32'(i));
    endtask

    // Called just after the start edge; leaves time just after edge 0.
    task automatic start_dump();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_sum = 32'd0;
        xfer_base = xfer_cnt;
        done_base = done_cnt;
        chk("start_busy",     32'(busy),        32'd1);
        chk("start_valid",    32'(out_valid),   32'd0);
        chk("start_checksum", checksum,         32'd0);
    endtask

    // Entered just after the edge that put the FSM in READ for word k.
    task automatic take_word(input int k, input int stall, input bit do_write, input bit pulse_start);
        chk($sformatf("read_addr_w%0d", k), 32'(rf_read_reg), 32'(k));
        @(posedge clk); #1;
        chk($sformatf("valid_w%0d", k), 32'(out_valid), 32'd1);
        chk($sformatf("index_w%0d", k), 32'(out_index), 32'(k));
        chk($sformatf("data_w%0d", k),  out_data,       exp_words[k]);
        if (do_write) begin
            regs[2] = 32'hDEAD_BEEF;
            regs[5] = 32'h1234_5678;
        end
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                chk($sformatf("stall_valid_w%0d_c%0d", k, s), 32'(out_valid), 32'd1);
                chk($sformatf("stall_data_w%0d_c%0d", k, s),  out_data,       exp_words[k]);
                chk($sformatf("stall_index_w%0d_c%0d", k, s), 32'(out_index), 32'(k));
                chk($sformatf("stall_sum_w%0d_c%0d", k, s),   checksum,       model_sum);
            end
            out_ready = 1'b1;
        end
        if (pulse_start) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_sum = model_sum ^ exp_words[k];
        chk($sformatf("xfer_valid_w%0d", k), 32'(out_valid), 32'd0);
        chk($sformatf("xfer_sum_w%0d", k),   checksum,       model_sum);
    endtask

    // Entered just after the last transfer edge (edge 16 with no stalls).
    task automatic finish_dump(input string name, input logic [31:0] exp_sum);
        chk({name, "_done_hi"}, 32'(done), 32'd1);
        chk({name, "_busy_hi"}, 32'(busy), 32'd1);
        chk({name, "_sum"},     checksum,  exp_sum);
        start = 1'b1;                       // start during DONE must be ignored
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_done_lo"},  32'(done),        32'd0);
        chk({name, "_busy_lo"},  32'(busy),        32'd0);
        chk({name, "_sum_hold"}, checksum,         exp_sum);
        chk({name, "_addr0"},    32'(rf_read_reg), 32'd0);
        @(posedge clk); #1;
        chk({name, "_idle"},     32'(busy),        32'd0);
        chk({name, "_ndone"},    32'(done_cnt - done_base), 32'd1);
        chk({name, "_nxfer"},    32'(xfer_cnt - xfer_base), 32'd8);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        regs[0]   = 32'd0;
        for (int i = 1; i < 8; i++) regs[i] = 32'hA5A5_0000 | 32'(i);

        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid),   32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_addr",  32'(rf_read_reg), 32'd0);
        chk("rst_sum",   checksum,         32'd0);
        #5 reset = 1'b0;

        // Idle with start low
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk($sformatf("idle_c%0d", i), {28'd0, out_valid, busy, done, 1'b0} | 32'(rf_read_reg), 32'd0);
        end

        // Dump 1: full sweep, consumer always ready
        set_base_words();
        start_dump();
        for (int k = 0; k < 8; k++) take_word(k, 0, 1'b0, 1'b0);
        finish_dump("sweep", 32'hA5A5_0000);

        // Dump 2: stall on word 2, writes during its HOLD, start during word 3
        set_base_words();
        exp_words[5] = 32'h1234_5678;
        start_dump();
        for (int k = 0; k < 8; k++) take_word(k, (k == 2) ? 3 : 0, k == 2, k == 3);
        finish_dump("bp", 32'h1234_567D);

        // Dump 3: asynchronous reset while word 4 is held
        set_base_words();
        exp_words[2] = 32'hDEAD_BEEF;
        exp_words[5] = 32'h1234_5678;
        start_dump();
        for (int k = 0; k < 4; k++) take_word(k, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid),   32'd0);
        chk("arst_busy",  32'(busy),        32'd0);
        chk("arst_done",  32'(done),        32'd0);
        chk("arst_addr",  32'(rf_read_reg), 32'd0);
        chk("arst_data",  out_data,         32'd0);
        chk("arst_index", 32'(out_index),   32'd0);
        chk("arst_sum",   checksum,         32'd0);
        #4 reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Dump 4: restarts at index 0 with the updated register contents
        start_dump();
        for (int k = 0; k < 8; k++) take_word(k, 0, 1'b0, 1'b0);
        finish_dump("rerun", 32'h693C_E890);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_regfile_dump.md
# mips_regfile_dump

Read-side sweeper for the 8×32 MIPS register file (`mips_registers`). On a start pulse it walks read port 1 through every register address and streams each captured word out over a valid/ready interface. While streaming it keeps a running XOR checksum. It replaces ad-hoc per-register reads in benches and debug paths with one ordered, back-pressurable dump of the whole register file.

## Interface
- ADDR_W, 3, register address width; register count NUM_REGS = 2**ADDR_W
- DATA_W, 32, register word width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a dump; sampled only in IDLE
- rf_read_reg  output  ADDR_W  address to register file read port 1
- rf_read_data  input  DATA_W  combinational read data from register file read port 1
- out_valid  output  1  out_data/out_index hold a word
- out_ready  input  1  consumer accepts the word on this edge when out_valid=1
- out_data  output  DATA_W  captured register contents
- out_index  output  ADDR_W  register number of out_data
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse after the last word transfers
- checksum  output  DATA_W  XOR of all words transferred in the current or last dump

## Operation
- FSM states: IDLE, READ, HOLD, DONE. All outputs are registered.
- IDLE:
  - rf_read_reg=0, out_valid=0.
  - If start=1 at an edge: idx←0, checksum←0, go to READ.
- READ:
  - rf_read_reg=idx.
  - At the next edge: out_data←rf_read_data, out_index←idx, out_valid←1, go to HOLD.
- HOLD:
  - out_valid=1. out_data and out_index are frozen; rf_read_data changes are ignored.
  - If out_ready=1 at an edge, the word transfers: checksum←checksum^out_data, out_valid←0.
  - After a transfer, go to DONE if idx=NUM_REGS-1; otherwise idx←idx+1 and go to READ.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - checksum keeps its final value until the next accepted start.
- start while busy=1 is ignored, including start in DONE.
- Register 0 is dumped like any other register. The register file returns 0 for it, so out_data=0 at index 0.
- Writes to the register file while a word is in HOLD do not affect that word.
  - A write to a not-yet-read address is reflected in the dump.
  - A write to an already-read address is not reflected.
- idx wraps to 0 only via a new start, never by incrementing past NUM_REGS-1.
- Reset, asynchronous at any time including mid-dump:
  - State←IDLE; idx, rf_read_reg, out_data, out_index, checksum←0; out_valid, busy, done←0.
  - The partial dump is discarded; the next start restarts at index 0.

## Timing
- Timeline below counts edges with start sampled at edge 0.
- Start to first word: READ during cycle 1, out_valid high after edge 1 (latency 1 cycle from acceptance).
- Per word:
  - With out_ready held high, each word takes 2 cycles (READ + HOLD). A full dump transfers the last word at edge 16.
  - done is high from edge 16 to edge 17. busy is low after edge 17.
- out_valid must not drop without a transfer. out_data and out_index are stable while out_valid=1 and out_ready=0.
- Transfer condition is out_valid & out_ready at the rising edge. out_ready has no combinational path to any output.

## Test plan
- Full sweep, no stall:
  - Preload r0=0 and r_i=32'hA5A5_0000|i for i=1..7. Pulse start with out_ready=1.
  - Expect 8 words in order, index 0..7, data 0, A5A50001..A5A50007.
  - done pulse after edge 16; checksum=32'hA5A5_0000; busy low after edge 17.
- Backpressure:
  - Hold out_ready=0 for 3 cycles while index 2 is valid.
  - Expect out_valid=1 and out_data=A5A50002 / out_index=2 unchanged, and no checksum update.
  - The transfer happens on the first edge with out_ready=1.
- Concurrent write:
  - While index 2 is in HOLD, write r2=32'hDEAD_BEEF and r5=32'h1234_5678.
  - Expect word 2 to remain A5A50002 and word 5 to read 12345678.
- Start while busy:
  - Pulse start again during index 3.
  - Expect no restart, a single done pulse, and 8 words total.
- Reset mid-dump:
  - Assert reset asynchronously during HOLD of index 4.
  - Expect all outputs 0 immediately.
  - A new start yields the full sequence from index 0 and a checksum recomputed from 0.
- Idle behaviour:
  - With start=0 for 20 cycles after reset, expect out_valid=0, busy=0, done=0, rf_read_reg=0.
